// File: rtl/npu_buffer_responder.sv
// Memory-side responder for one NPU weight/activation buffer: fixed-latency core reads,
// core/DMA writes with core priority, and a full-array clear sweep after every reset.
module npu_buffer_responder #(
  parameter int DATA_W     = 128,
  parameter int ADDR_WIDTH = 18,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  dma_wr_valid,
  output logic                  dma_wr_ready,
  input  logic [ADDR_WIDTH-1:0] dma_wr_addr,
  input  logic [DATA_W-1:0]     dma_wr_data,
  output logic                  init_done,
  output logic                  oob_err
);

  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_in, wr_in, dma_in, dma_fire;
  logic [IDX_W-1:0]  rd_idx, wr_idx, dma_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  // Range check is done on the zero-extended address so DEPTH == 2**ADDR_WIDTH still works.
  assign rd_in    = {1'b0, rd_addr}     < DEPTH_X;
  assign wr_in    = {1'b0, wr_addr}     < DEPTH_X;
  assign dma_in   = {1'b0, dma_wr_addr} < DEPTH_X;
  assign rd_idx   = rd_addr[IDX_W-1:0];
  assign wr_idx   = wr_addr[IDX_W-1:0];
  assign dma_idx  = dma_wr_addr[IDX_W-1:0];
  assign dma_fire = dma_wr_valid & dma_wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  // The single write port is shared by the clear sweep, the core and the DMA, in that priority.
  always_comb begin
    state_nxt    = state;
    init_done    = 1'b0;
    dma_wr_ready = 1'b0;
    mem_we       = 1'b0;
    mem_idx      = clr_ptr;
    mem_wdata    = '0;
    case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (clr_ptr == LAST_IDX) state_nxt = S_RUN;
      end
      S_RUN: begin
        init_done    = 1'b1;
        dma_wr_ready = !wr_en;
        if (wr_en) begin
          mem_we    = wr_in;
          mem_idx   = wr_idx;
          mem_wdata = wr_data;
        end else if (dma_wr_valid) begin
          mem_we    = dma_in;
          mem_idx   = dma_idx;
          mem_wdata = dma_wr_data;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 clr_ptr <= '0;
    else if (state == S_CLEAR)  clr_ptr <= clr_ptr + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oob_err <= 1'b0;
    else if ((rd_en && !rd_in) || (wr_en && !wr_in) || (dma_fire && !dma_in)) oob_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  // Write-first bypass: a same-cycle committed write to the read index wins over the array.
  always_comb begin
    rd_word = '0;
    if (state == S_RUN && rd_in) begin
      if (mem_we && mem_idx == rd_idx) rd_word = mem_wdata;
      else                             rd_word = mem[rd_idx];
    end
  end

  // Stage 0 samples the array; later stages only advance behind a valid so rd_data holds.
  logic [DATA_W-1:0]     data_p [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < RD_LATENCY; k++) data_p[k] <= '0;
    end else begin
      vld_p[0] <= rd_en;
      if (rd_en) data_p[0] <= rd_word;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) data_p[k] <= data_p[k-1];
      end
    end
  end

  assign rd_data  = data_p[RD_LATENCY-1];
  assign rd_valid = vld_p[RD_LATENCY-1];

endmodule
